smpl_cmp_avmm_master: RTL and testbench

Avalon-MM initiator that runs one sample-compare cycle against the sample-compare register slaves. It writes the 2-bit compare-enable register, polls a status register at a fixed interval until the done bit sets, then writes the enable register back to zero and reports pass/fail. It sits in the fabric alongside the NIOS so that FPGA logic can start a compare run without CPU involvement. Slaves are zero-read-latency: readdata is valid in the cycle the read is accepted.

---
 rtl/smpl_cmp_avmm_master_pkg.sv | 18 +
 rtl/smpl_cmp_poll_timer.sv | 29 ++
 rtl/smpl_cmp_avmm_master.sv | 146 ++++++++++++++
 tb/tb_smpl_cmp_avmm_master.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smpl_cmp_avmm_master_pkg.sv
// Shared types and constants for the sample-compare Avalon-MM master.
// Holds the FSM state encoding, status register bit positions and counter width.
package smpl_cmp_avmm_master_pkg;

    localparam int CNT_W             = 16;
    localparam int STAT_DONE_BIT     = 0;
    localparam int STAT_MISMATCH_BIT = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_EN,
        S_POLL_WAIT,
        S_RD_STAT,
        S_WR_DIS,
        S_DONE
    } state_t;

endpackage

// File: rtl/smpl_cmp_poll_timer.sv
// Loadable 16-bit down-counter that paces status polls.
// The expiring flag marks the cycle whose decrement brings the count to zero.
module smpl_cmp_poll_timer
    import smpl_cmp_avmm_master_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             expiring
);

    logic [CNT_W-1:0] count;

    // Saturates at zero instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expiring = (count <= CNT_W'(1));

endmodule

// File: rtl/smpl_cmp_avmm_master.sv
// Avalon-MM initiator: enable compare, poll status until done, disable, report pass/fail.
// Optional poll timeout is built when SMPL_CMP_TIMEOUT_EN is defined.
module smpl_cmp_avmm_master
    import smpl_cmp_avmm_master_pkg::*;
#(
    parameter int         ADDR_W        = 4,
    parameter int         EN_ADDR       = 0,
    parameter int         STAT_ADDR     = 1,
    parameter logic [1:0] EN_VALUE      = 2'b11,
    parameter int         POLL_INTERVAL = 16,
    parameter int         TIMEOUT_POLLS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic              avm_read,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);

    state_t state;
    logic   accept;
    logic   stat_done;
    logic   stat_mismatch;
    logic   timeout_hit;
    logic   timer_load;
    logic   timer_dec;
    logic   timer_expiring;
    logic   unused_rdata;

    assign accept        = !avm_waitrequest;
    assign stat_done     = avm_readdata[STAT_DONE_BIT];
    assign stat_mismatch = avm_readdata[STAT_MISMATCH_BIT];
    assign unused_rdata  = ^avm_readdata[31:2];

`ifdef SMPL_CMP_TIMEOUT_EN
    logic [CNT_W-1:0] poll_cnt;
    assign timeout_hit = (poll_cnt == CNT_W'(TIMEOUT_POLLS - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_POLLS;
    assign timeout_hit        = 1'b0;
`endif

    // Interval restarts after the enable write and after every not-done status read.
    assign timer_load = accept && ((state == S_WR_EN) ||
                        ((state == S_RD_STAT) && !stat_done && !timeout_hit));
    assign timer_dec  = (state == S_POLL_WAIT);

    smpl_cmp_poll_timer u_poll_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (CNT_W'(POLL_INTERVAL)),
        .dec        (timer_dec),
        .expiring   (timer_expiring)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
`ifdef SMPL_CMP_TIMEOUT_EN
            poll_cnt      <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state         <= S_WR_EN;
                        busy          <= 1'b1;
                        pass          <= 1'b0;
                        timeout       <= 1'b0;
                        avm_write     <= 1'b1;
                        avm_address   <= ADDR_W'(EN_ADDR);
                        avm_writedata <= {30'b0, EN_VALUE};
`ifdef SMPL_CMP_TIMEOUT_EN
                        poll_cnt      <= '0;
`endif
                    end
                end
                S_WR_EN: begin
                    if (accept) begin
                        avm_write     <= 1'b0;
                        avm_writedata <= '0;
                        state         <= S_POLL_WAIT;
                    end
                end
                S_POLL_WAIT: begin
                    if (timer_expiring) begin
                        avm_read    <= 1'b1;
                        avm_address <= ADDR_W'(STAT_ADDR);
                        state       <= S_RD_STAT;
                    end
                end
                S_RD_STAT: begin
                    if (accept) begin
                        avm_read <= 1'b0;
`ifdef SMPL_CMP_TIMEOUT_EN
                        if (poll_cnt != '1) poll_cnt <= poll_cnt + 1'b1;
`endif
                        // Done bit takes priority over a timeout on the same read.
                        if (stat_done || timeout_hit) begin
                            pass          <= stat_done ? !stat_mismatch : 1'b0;
                            timeout       <= !stat_done;
                            avm_write     <= 1'b1;
                            avm_address   <= ADDR_W'(EN_ADDR);
                            avm_writedata <= '0;
                            state         <= S_WR_DIS;
                        end else begin
                            state <= S_POLL_WAIT;
                        end
                    end
                end
                S_WR_DIS: begin
                    if (accept) begin
                        avm_write <= 1'b0;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_smpl_cmp_avmm_master.sv
// Directed bench for smpl_cmp_avmm_master with a zero-latency slave model.
// Build with SMPL_CMP_TIMEOUT_EN defined to exercise the bounded-poll variant.
module tb_smpl_cmp_avmm_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [3:0]  avm_address;
    logic        avm_write;
    logic        avm_read;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    smpl_cmp_avmm_master #(
        .ADDR_W(4), .EN_ADDR(0), .STAT_ADDR(1), .EN_VALUE(2'b11),
        .POLL_INTERVAL(4), .TIMEOUT_POLLS(5)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .pass(pass), .timeout(timeout), .avm_address(avm_address),
        .avm_write(avm_write), .avm_read(avm_read), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
    );

    // Slave model: each transfer stalls stall_n cycles; status comes from stat_tab then stat_fill.
    int          stall_n = 0;
    int          wr_cnt  = 0;
    int          rd_cnt  = 0;
    int          rd_base = 0;
    int          cyc     = 0;
    int          ri;
    logic [31:0] stat_tab [0:7];
    int          stat_len = 0;
    logic [31:0] stat_fill = 32'h0;

    assign avm_waitrequest = (avm_read || avm_write) && (wr_cnt < stall_n);

    always_comb begin
        ri = rd_cnt - rd_base;
        avm_readdata = (ri < stat_len) ? stat_tab[ri[2:0]] : stat_fill;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if ((avm_read || avm_write) && avm_waitrequest) wr_cnt <= wr_cnt + 1;
        else wr_cnt <= 0;
        if (avm_read && !avm_waitrequest) rd_cnt <= rd_cnt + 1;
    end

    // Monitor: accepted transfers, stall stability, done pulses.
    logic [36:0] log_x [$];
    int          log_cyc [$];
    logic [38:0] saved;
    logic        stalled_prev = 1'b0;
    int          stab_err = 0, stab_chk = 0, both_err = 0, done_cnt = 0, done_cyc = 0;
    logic        done_pass = 1'b0, done_to = 1'b0;

    always @(negedge clk) begin
        if (stalled_prev) begin
            stab_chk = stab_chk + 1;
            if ({avm_read, avm_write, avm_address, avm_writedata} !== saved) stab_err = stab_err + 1;
        end
        stalled_prev = (avm_read || avm_write) && avm_waitrequest;
        saved = {avm_read, avm_write, avm_address, avm_writedata};
        if (avm_read && avm_write) both_err = both_err + 1;
        if ((avm_read || avm_write) && !avm_waitrequest) begin
            log_x.push_back({avm_write, avm_address, avm_write ? avm_writedata : 32'h0});
            log_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt  = done_cnt + 1;
            done_cyc  = cyc;
            done_pass = pass;
            done_to   = timeout;
        end
    end

    int start_cyc, done_base, stab_base, chk_base, both_base, n_rd;
    bit wait_ok;
    localparam logic [36:0] X_WR_EN  = {1'b1, 4'd0, 32'h3};
    localparam logic [36:0] X_RD     = {1'b0, 4'd1, 32'h0};
    localparam logic [36:0] X_WR_DIS = {1'b1, 4'd0, 32'h0};

    task automatic setup(input int stalls, input logic [31:0] fill, input int len);
        stall_n   = stalls;
        stat_fill = fill;
        stat_len  = len;
        rd_base   = rd_cnt;
        done_base = done_cnt;
        stab_base = stab_err;
        chk_base  = stab_chk;
        both_base = both_err;
        log_x.delete();
        log_cyc.delete();
    endtask

    task automatic run_start();
        @(negedge clk);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        wait_ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk); #1;
            if (done_cnt != done_base) begin
                wait_ok = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!wait_ok) begin
            tests_failed++;
            $display("FAIL done_wait: no done pulse within %0d cycles, required one", max_cyc);
        end
    endtask

    task automatic count_reads();
        n_rd = 0;
        foreach (log_x[i]) if (!log_x[i][36]) n_rd++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, done, pass, timeout, avm_read, avm_write, avm_address, avm_writedata} !== 42'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got busy=%b done=%b pass=%b to=%b rd=%b wr=%b addr=%h wd=%h, required all 0",
                     busy, done, pass, timeout, avm_read, avm_write, avm_address, avm_writedata);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        setup(0, 32'h1, 0);
        run_start();
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_busy: got %b, required 1", busy);
        end
        wait_done(40);
        tests_run++;
        if (done_cyc - start_cyc !== 9) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d, required 9", done_cyc - start_cyc);
        end
        tests_run++;
        if ({done_pass, done_to} !== 2'b10) begin
            tests_failed++;
            $display("FAIL basic_result: got pass=%b timeout=%b, required pass=1 timeout=0", done_pass, done_to);
        end
        tests_run++;
        if (log_x.size() != 3 || log_x[0] !== X_WR_EN || log_x[1] !== X_RD || log_x[2] !== X_WR_DIS) begin
            tests_failed++;
            $display("FAIL basic_transfers: got %0d transfers first=%h, required 3 (wr 0=3, rd 1, wr 0=0)",
                     log_x.size(), (log_x.size() > 0) ? log_x[0] : 37'h0);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_idle_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_mismatch();
        setup(0, 32'h0, 4);
        stat_tab[0] = 32'h0; stat_tab[1] = 32'h0; stat_tab[2] = 32'h0; stat_tab[3] = 32'h3;
        run_start();
        wait_done(60);
        count_reads();
        tests_run++;
        if (n_rd != 4) begin
            tests_failed++;
            $display("FAIL mismatch_reads: got %0d reads, required 4", n_rd);
        end
        tests_run++;
        if (log_cyc.size() != 6 || log_cyc[2] - log_cyc[1] != 5 || log_cyc[3] - log_cyc[2] != 5 ||
            log_cyc[4] - log_cyc[3] != 5) begin
            tests_failed++;
            $display("FAIL mismatch_spacing: got %0d transfers, required reads 5 cycles apart", log_cyc.size());
        end
        tests_run++;
        if ({done_pass, done_to} !== 2'b00) begin
            tests_failed++;
            $display("FAIL mismatch_result: got pass=%b timeout=%b, required 0/0", done_pass, done_to);
        end
        tests_run++;
        if (done_cyc - start_cyc !== 24) begin
            tests_failed++;
            $display("FAIL mismatch_latency: got %0d, required 24", done_cyc - start_cyc);
        end
    endtask

    task automatic test_stall();
        setup(3, 32'h1, 0);
        run_start();
        wait_done(60);
        tests_run++;
        if (done_cyc - start_cyc !== 18) begin
            tests_failed++;
            $display("FAIL stall_latency: got %0d, required 18", done_cyc - start_cyc);
        end
        tests_run++;
        if (stab_err - stab_base != 0 || stab_chk - chk_base != 9) begin
            tests_failed++;
            $display("FAIL stall_stable: got %0d changes over %0d stall cycles, required 0 over 9",
                     stab_err - stab_base, stab_chk - chk_base);
        end
        tests_run++;
        if (log_x.size() != 3 || log_x[0] !== X_WR_EN || log_x[1] !== X_RD || log_x[2] !== X_WR_DIS) begin
            tests_failed++;
            $display("FAIL stall_transfers: got %0d transfers, required 3", log_x.size());
        end
        tests_run++;
        if (both_err - both_base != 0 || done_pass !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_result: got overlap=%0d pass=%b, required 0 and 1", both_err - both_base, done_pass);
        end
    endtask

    task automatic test_timeout();
`ifdef SMPL_CMP_TIMEOUT_EN
        setup(0, 32'h0, 0);
        run_start();
        wait_done(60);
        count_reads();
        tests_run++;
        if (n_rd != 5 || log_x.size() != 7 || log_x[6] !== X_WR_DIS) begin
            tests_failed++;
            $display("FAIL timeout_transfers: got %0d reads %0d transfers, required 5 reads then disable write",
                     n_rd, log_x.size());
        end
        tests_run++;
        if ({done_pass, done_to} !== 2'b01 || done_cyc - start_cyc !== 29) begin
            tests_failed++;
            $display("FAIL timeout_result: got pass=%b timeout=%b latency=%0d, required 0/1/29",
                     done_pass, done_to, done_cyc - start_cyc);
        end
        setup(0, 32'h0, 5);
        stat_tab[0] = 32'h0; stat_tab[1] = 32'h0; stat_tab[2] = 32'h0; stat_tab[3] = 32'h0;
        stat_tab[4] = 32'h1;
        run_start();
        wait_done(60);
        tests_run++;
        if ({done_pass, done_to} !== 2'b10) begin
            tests_failed++;
            $display("FAIL timeout_done_wins: got pass=%b timeout=%b, required 1/0", done_pass, done_to);
        end
`else
        setup(0, 32'h0, 0);
        run_start();
        repeat (560) @(negedge clk);
        count_reads();
        tests_run++;
        if (n_rd < 100) begin
            tests_failed++;
            $display("FAIL unbounded_reads: got %0d reads, required at least 100", n_rd);
        end
        tests_run++;
        if (done_cnt != done_base || timeout !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL unbounded_state: got done_pulses=%0d timeout=%b busy=%b, required 0/0/1",
                     done_cnt - done_base, timeout, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif
    endtask

    task automatic test_reset_mid();
        setup(10, 32'h1, 0);
        run_start();
        tests_run++;
        if ({avm_write, avm_waitrequest} !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_mid_pre: got write=%b waitrequest=%b, required 1/1", avm_write, avm_waitrequest);
        end
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({avm_write, avm_read, busy, done} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_mid_drop: got write=%b read=%b busy=%b done=%b, required all 0",
                     avm_write, avm_read, busy, done);
        end
        reset = 1'b0;
        setup(0, 32'h1, 0);
        run_start();
        wait_done(40);
        tests_run++;
        if (done_pass !== 1'b1 || done_cyc - start_cyc !== 9 || log_x.size() != 3 || log_x[0] !== X_WR_EN) begin
            tests_failed++;
            $display("FAIL reset_mid_rerun: got pass=%b latency=%0d transfers=%0d, required 1/9/3",
                     done_pass, done_cyc - start_cyc, log_x.size());
        end
    endtask

    task automatic test_start_ignored();
        setup(0, 32'h0, 2);
        stat_tab[0] = 32'h0; stat_tab[1] = 32'h1;
        run_start();
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(60);
        repeat (30) @(negedge clk);
        tests_run++;
        if (done_cnt - done_base != 1 || log_x.size() != 4) begin
            tests_failed++;
            $display("FAIL start_ignored: got %0d done pulses %0d transfers, required 1 and 4",
                     done_cnt - done_base, log_x.size());
        end
        tests_run++;
        if (done_cyc - start_cyc !== 14 || done_pass !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_ignored_run: got latency=%0d pass=%b, required 14 and 1",
                     done_cyc - start_cyc, done_pass);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_stall();
        test_timeout();
        test_reset_mid();
        test_start_ignored();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
